// File: rtl/issue_window_pkg.sv
// Decode types, issue-block reasons and shared constants for the in-order issue window.
package issue_window_pkg;

  localparam int MAX_ISSUE_WIDTH = 4;
  localparam logic [4:0] ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [4:0] write_reg_addr;
    logic       reg_write;
    logic       is_branch;
    logic       is_mdu;
    logic       is_mem_access;
  } partial_decode_t;

  typedef enum logic [2:0] {
    NONE, RAW, WAW, WAR, CTRL, MEM, MDU_BUSY
  } issue_block_reason_e;

  function automatic logic writes_reg(input partial_decode_t d);
    return d.reg_write && (d.write_reg_addr != ZERO);
  endfunction

endpackage

// File: rtl/issue_window_if.sv
// Enqueue and issue bundle between decode, the issue window and register read.
interface issue_window_if import issue_window_pkg::*; #(
  parameter int IN_WIDTH    = 2,
  parameter int ISSUE_WIDTH = 2
);
  logic [IN_WIDTH-1:0]                in_valid;
  partial_decode_t [IN_WIDTH-1:0]     in_decode;
  logic [IN_WIDTH-1:0][31:0]          in_pc;
  logic                               in_ready;
  logic [ISSUE_WIDTH-1:0]             out_valid;
  partial_decode_t [ISSUE_WIDTH-1:0]  out_decode;
  logic [ISSUE_WIDTH-1:0][31:0]       out_pc;

  modport master (
    output in_valid, in_decode, in_pc,
    input  in_ready, out_valid, out_decode, out_pc
  );

  modport slave (
    input  in_valid, in_decode, in_pc,
    output in_ready, out_valid, out_decode, out_pc
  );
endinterface

// File: rtl/issue_group_checker.sv
// Combinational legality check of the head candidates: longest legal in-order prefix plus per-slot block reason.
module issue_group_checker import issue_window_pkg::*; #(
  parameter int ISSUE_WIDTH = 2,
  parameter int MEM_PORTS   = 1
) (
  input  partial_decode_t [ISSUE_WIDTH-1:0] cand,
  input  logic [ISSUE_WIDTH-1:0]            cand_valid,
  input  logic                              mdu_busy,
  input  logic                              issue_stall,
  output logic [ISSUE_WIDTH-1:0]            legal,
  output issue_block_reason_e               reason [ISSUE_WIDTH]
);

  localparam int SLOTS = (ISSUE_WIDTH < MAX_ISSUE_WIDTH) ? ISSUE_WIDTH : MAX_ISSUE_WIDTH;

  always_comb begin
    logic raw, waw, war, ctrl, chain;
    int   mem_cnt;
    legal = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) reason[k] = NONE;
    raw     = 1'b0;
    waw     = 1'b0;
    war     = 1'b0;
    ctrl    = 1'b0;
    chain   = ~issue_stall;
    mem_cnt = 0;
    for (int k = 0; k < SLOTS; k++) begin
      mem_cnt = mem_cnt + int'(cand[k].is_mem_access);
      ctrl    = cand[k].is_branch | cand[k].is_mdu;
      raw     = 1'b0;
      waw     = 1'b0;
      war     = 1'b0;
      for (int j = 0; j < k; j++) begin
        raw  = raw | (writes_reg(cand[j]) &&
               (cand[j].write_reg_addr == cand[k].rs_addr || cand[j].write_reg_addr == cand[k].rt_addr));
        waw  = waw | (writes_reg(cand[j]) && writes_reg(cand[k]) &&
               cand[j].write_reg_addr == cand[k].write_reg_addr);
        war  = war | (writes_reg(cand[k]) &&
               (cand[k].write_reg_addr == cand[j].rs_addr || cand[k].write_reg_addr == cand[j].rt_addr));
        ctrl = ctrl | cand[j].is_branch | cand[j].is_mdu;
      end
      // Slot 0 only waits on the MDU; everything else gates the younger slots.
      if (k == 0) begin
        if (cand[0].is_mdu && mdu_busy) reason[0] = MDU_BUSY;
      end else if (raw)                reason[k] = RAW;
      else if (waw)                    reason[k] = WAW;
      else if (war)                    reason[k] = WAR;
      else if (ctrl)                   reason[k] = CTRL;
      else if (mem_cnt > MEM_PORTS)    reason[k] = MEM;
      chain    = chain & cand_valid[k] & (reason[k] == NONE);
      legal[k] = chain;
    end
  end

endmodule

// File: rtl/issue_window.sv
// Circular issue queue between decode and register read; issues the longest legal in-order head prefix.
// Optional ISSUE_WINDOW_PERF_EN adds saturating issue-width histogram and dependency-stall counters.
module issue_window import issue_window_pkg::*; #(
  parameter int DEPTH       = 8,
  parameter int IN_WIDTH    = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int MEM_PORTS   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         issue_stall,
  input  logic                         mdu_busy,
  issue_window_if.slave                win,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef ISSUE_WINDOW_PERF_EN
  ,
  output logic [ISSUE_WIDTH:0][31:0]   perf_issue_hist,
  output logic [31:0]                  perf_dep_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]                  head, tail;
  logic [CNT_W-1:0]                  count, n_enq, n_issue;
  logic [DEPTH-1:0]                  entry_valid;
  partial_decode_t                   entry_dec [DEPTH];
  logic [31:0]                       entry_pc  [DEPTH];
  partial_decode_t [ISSUE_WIDTH-1:0] cand;
  logic [ISSUE_WIDTH-1:0]            cand_valid, legal;
  issue_block_reason_e               reason [ISSUE_WIDTH];
  logic                              enq_fire, unused_reason;

  // Space is judged on the registered count only, so same-cycle issue never frees room.
  assign win.in_ready = (count <= CNT_W'(DEPTH - IN_WIDTH));
  assign enq_fire     = win.in_ready && (|win.in_valid);
  assign n_enq        = enq_fire ? CNT_W'($countones(win.in_valid)) : '0;
  assign n_issue      = CNT_W'($countones(legal));
  assign occupancy    = count;
  assign win.out_valid  = legal;
  assign win.out_decode = cand;

  always_comb begin
    logic [PTR_W-1:0] idx;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      idx            = head + PTR_W'(k);
      cand[k]        = entry_dec[idx];
      win.out_pc[k]  = entry_pc[idx];
      cand_valid[k]  = (CNT_W'(k) < count) && entry_valid[idx];
    end
  end

  issue_group_checker #(.ISSUE_WIDTH(ISSUE_WIDTH), .MEM_PORTS(MEM_PORTS)) u_checker (
    .cand        (cand),
    .cand_valid  (cand_valid),
    .mdu_busy    (mdu_busy),
    .issue_stall (issue_stall),
    .legal       (legal),
    .reason      (reason)
  );

  always_comb begin
    unused_reason = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) unused_reason = unused_reason ^ (^reason[k]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else if (flush) begin
      head        <= tail;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      for (int k = 0; k < ISSUE_WIDTH; k++)
        if (legal[k]) entry_valid[head + PTR_W'(k)] <= 1'b0;
      for (int i = 0; i < IN_WIDTH; i++)
        if (enq_fire && win.in_valid[i]) entry_valid[tail + PTR_W'(i)] <= 1'b1;
      head  <= head + PTR_W'(n_issue);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + n_enq - n_issue;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (!flush && enq_fire && win.in_valid[i]) begin
        entry_dec[tail + PTR_W'(i)] <= win.in_decode[i];
        entry_pc[tail + PTR_W'(i)]  <= win.in_pc[i];
      end
    end
  end

  a_in_valid_packed: assert property (@(posedge clk) disable iff (!reset_n)
    ((win.in_valid & (win.in_valid + IN_WIDTH'(1))) == '0));

`ifdef ISSUE_WINDOW_PERF_EN
  logic dep_hit;

  if (ISSUE_WIDTH > 1) begin : g_dep
    assign dep_hit = (count >= CNT_W'(2)) && (reason[1] inside {RAW, WAW, WAR});
  end else begin : g_no_dep
    assign dep_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_hist <= '0;
      perf_dep_stall  <= '0;
    end else if (!flush) begin
      if (count != '0) begin
        for (int n = 0; n <= ISSUE_WIDTH; n++)
          if (n_issue == CNT_W'(n) && perf_issue_hist[n] != '1)
            perf_issue_hist[n] <= perf_issue_hist[n] + 32'd1;
      end
      if (dep_hit && perf_dep_stall != '1) perf_dep_stall <= perf_dep_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_window.sv
// Randomized and directed bench for issue_window against a queue-based reference of the issue rules.
module tb_issue_window;
  import issue_window_pkg::*;

  localparam int DEPTH = 8, IN_W = 2, ISS_W = 2, MEM_PORTS = 1;

  typedef struct {
    partial_decode_t dec;
    logic [31:0]     pc;
  } entry_t;

  logic       clk = 1'b0, reset_n = 1'b0, flush = 1'b0, issue_stall = 1'b0, mdu_busy = 1'b0;
  logic [3:0] occupancy;
  entry_t     q[$];
  int         n_cmp = 0, n_bad = 0;
  logic [31:0] pc_next = 32'h0040_0000;
  longint     exp_hist [ISS_W+1];
  longint     exp_dep = 0;

  issue_window_if #(.IN_WIDTH(IN_W), .ISSUE_WIDTH(ISS_W)) win();

`ifdef ISSUE_WINDOW_PERF_EN
  logic [ISS_W:0][31:0] perf_issue_hist;
  logic [31:0]          perf_dep_stall;
`endif

  issue_window #(.DEPTH(DEPTH), .IN_WIDTH(IN_W), .ISSUE_WIDTH(ISS_W), .MEM_PORTS(MEM_PORTS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .issue_stall     (issue_stall),
    .mdu_busy        (mdu_busy),
    .win             (win.slave),
    .occupancy       (occupancy)
`ifdef ISSUE_WINDOW_PERF_EN
    ,
    .perf_issue_hist (perf_issue_hist),
    .perf_dep_stall  (perf_dep_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic wr(input partial_decode_t d);
    return d.reg_write && d.write_reg_addr != 5'd0;
  endfunction

  function automatic issue_block_reason_e hazard(input partial_decode_t older, input partial_decode_t younger);
    if (wr(older) && (older.write_reg_addr == younger.rs_addr || older.write_reg_addr == younger.rt_addr))
      return RAW;
    if (wr(older) && wr(younger) && older.write_reg_addr == younger.write_reg_addr) return WAW;
    if (wr(younger) && (younger.write_reg_addr == older.rs_addr || younger.write_reg_addr == older.rt_addr))
      return WAR;
    return NONE;
  endfunction

  // Number of instructions the spec's rules allow from the head of the reference queue.
  function automatic int model_issue(input logic stall, input logic busy);
    int mem;
    if (stall || q.size() == 0) return 0;
    if (q[0].dec.is_mdu && busy) return 0;
    if (q[0].dec.is_branch || q[0].dec.is_mdu) return 1;
    mem = int'(q[0].dec.is_mem_access);
    for (int k = 1; k < ISS_W && k < q.size(); k++) begin
      if (q[k].dec.is_branch || q[k].dec.is_mdu) return k;
      for (int j = 0; j < k; j++)
        if (hazard(q[j].dec, q[k].dec) != NONE) return k;
      mem += int'(q[k].dec.is_mem_access);
      if (mem > MEM_PORTS) return k;
    end
    return (q.size() < ISS_W) ? q.size() : ISS_W;
  endfunction

  function automatic partial_decode_t mk(input int rd, input int rs, input int rt,
                                         input logic w, input logic br, input logic md, input logic mm);
    partial_decode_t d;
    d.write_reg_addr = 5'(rd);
    d.rs_addr        = 5'(rs);
    d.rt_addr        = 5'(rt);
    d.reg_write      = w;
    d.is_branch      = br;
    d.is_mdu         = md;
    d.is_mem_access  = mm;
    return d;
  endfunction

  function automatic partial_decode_t rand_dec();
    int cls;
    cls = $urandom_range(0, 9);
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 3) != 0), cls == 0, cls == 1, cls == 2 || cls == 3);
  endfunction

  task automatic set_in(input int n, input partial_decode_t d0, input partial_decode_t d1);
    win.in_valid     = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    win.in_decode[0] = d0;
    win.in_decode[1] = d1;
    win.in_pc[0]     = pc_next;
    win.in_pc[1]     = pc_next + 32'd4;
    pc_next          = pc_next + 32'd8;
  endtask

  task automatic idle();
    win.in_valid = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks outputs, advances model and DUT one cycle.
  task automatic cycle();
    int   n_iss, n_en;
    logic exp_ready;
    #1;
    exp_ready = (q.size() <= DEPTH - IN_W);
    n_iss     = model_issue(issue_stall, mdu_busy);
    check_eq("in_ready", win.in_ready, exp_ready);
    check_eq("occupancy", occupancy, q.size());
    check_eq("out_valid", win.out_valid, (1 << n_iss) - 1);
    for (int k = 0; k < n_iss; k++) begin
      check_eq($sformatf("out_pc%0d", k), win.out_pc[k], q[k].pc);
      check_eq($sformatf("out_decode%0d", k), win.out_decode[k], q[k].dec);
    end
    if (!flush && q.size() > 0) exp_hist[n_iss]++;
    if (!flush && q.size() >= 2 && hazard(q[0].dec, q[1].dec) != NONE) exp_dep++;
    n_en = exp_ready ? $countones(win.in_valid) : 0;
    if (flush) q.delete();
    else begin
      repeat (n_iss) void'(q.pop_front());
      for (int i = 0; i < n_en; i++) q.push_back('{dec: win.in_decode[i], pc: win.in_pc[i]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int n = 0; n <= ISS_W; n++) exp_hist[n] = 0;
    idle();
    win.in_decode = '0;
    win.in_pc     = '0;
    #12;
    check_eq("reset_out_valid", win.out_valid, 0);
    check_eq("reset_occupancy", occupancy, 0);
    check_eq("reset_in_ready", win.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // independent ALU pair, then RAW pair
    set_in(2, mk(1, 2, 3, 1, 0, 0, 0), mk(4, 5, 6, 1, 0, 0, 0)); cycle();
    idle(); cycle(); cycle();
    set_in(2, mk(1, 2, 3, 1, 0, 0, 0), mk(4, 1, 5, 1, 0, 0, 0)); cycle();
    idle(); cycle(); cycle(); cycle();
    // lw/sw share one port; beq issues alone
    set_in(2, mk(8, 9, 8, 1, 0, 0, 1), mk(0, 11, 10, 0, 0, 0, 1)); cycle();
    set_in(2, mk(0, 1, 2, 0, 1, 0, 0), mk(3, 4, 5, 1, 0, 0, 0)); cycle();
    idle(); repeat (4) cycle();
    // mult waits on a busy MDU for three cycles
    mdu_busy = 1'b1;
    set_in(1, mk(0, 2, 3, 0, 0, 1, 0), '0); cycle();
    idle(); repeat (3) cycle();
    mdu_busy = 1'b0; cycle(); cycle();

    // fill under stall, then drain through pointer wrap
    issue_stall = 1'b1;
    repeat (5) begin set_in(2, rand_dec(), rand_dec()); cycle(); end
    #1;
    check_eq("full_in_ready", win.in_ready, (q.size() >= 7) ? 0 : 1);
    check_eq("full_occupancy", occupancy, 8);
    issue_stall = 1'b0;
    repeat (20) begin set_in(2, mk(1, 2, 3, 1, 0, 0, 0), mk(4, 5, 6, 1, 0, 0, 0)); cycle(); end
    idle(); repeat (12) cycle();

    // flush at occupancy 5 with a simultaneous enqueue, then flush while empty
    issue_stall = 1'b1;
    set_in(2, rand_dec(), rand_dec()); cycle();
    set_in(2, rand_dec(), rand_dec()); cycle();
    set_in(1, rand_dec(), rand_dec()); cycle();
    #1 check_eq("pre_flush_occ", occupancy, 5);
    flush = 1'b1;
    set_in(2, rand_dec(), rand_dec()); cycle();
    flush = 1'b0; issue_stall = 1'b0; idle(); cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();

    repeat (600) begin
      flush       = ($urandom_range(0, 99) < 3);
      issue_stall = ($urandom_range(0, 99) < 20);
      mdu_busy    = ($urandom_range(0, 99) < 30);
      set_in($urandom_range(0, 2), rand_dec(), rand_dec());
      cycle();
    end

    // asynchronous reset in the middle of a busy queue
    flush = 1'b0; issue_stall = 1'b1; mdu_busy = 1'b0;
    set_in(2, rand_dec(), rand_dec()); cycle(); cycle();
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_out_valid", win.out_valid, 0);
    check_eq("midreset_occupancy", occupancy, 0);
    check_eq("midreset_in_ready", win.in_ready, 1);
`ifdef ISSUE_WINDOW_PERF_EN
    check_eq("midreset_perf_dep", perf_dep_stall, 0);
`endif
    q.delete();
    for (int n = 0; n <= ISS_W; n++) exp_hist[n] = 0;
    exp_dep = 0;
    @(negedge clk);
    reset_n = 1'b1;
    issue_stall = 1'b0;

    repeat (300) begin
      flush       = ($urandom_range(0, 99) < 3);
      issue_stall = ($urandom_range(0, 99) < 15);
      mdu_busy    = ($urandom_range(0, 99) < 25);
      set_in($urandom_range(0, 2), rand_dec(), rand_dec());
      cycle();
    end
    flush = 1'b0; issue_stall = 1'b0; mdu_busy = 1'b0; idle();
    repeat (10) cycle();

`ifdef ISSUE_WINDOW_PERF_EN
    for (int n = 0; n <= ISS_W; n++)
      check_eq($sformatf("perf_issue_hist%0d", n), perf_issue_hist[n], exp_hist[n]);
    check_eq("perf_dep_stall", perf_dep_stall, exp_dep);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_window.md
Name: issue_window

Overview:
- Parametrised in-order issue stage for the superscalar MIPS pipeline, placed between decode and register read.
- Buffers partially decoded instructions in a circular queue of DEPTH entries and accepts up to IN_WIDTH instructions per cycle.
- Each cycle, issues the longest legal in-order prefix of up to ISSUE_WIDTH instructions from the head.
- Generalises the pairwise dual-issue rule to N slots. Adds buffering, back-pressure, flush, and MDU-busy and memory-port constraints.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4, must be >= IN_WIDTH.
- IN_WIDTH, 2, enqueue lanes per cycle.
- ISSUE_WIDTH, 2, maximum instructions issued per cycle; range 1..4.
- MEM_PORTS, 1, maximum is_mem_access instructions per issue group.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards all queued entries.
- in_valid  in  IN_WIDTH  per-lane enqueue valid; must be packed from lane 0.
- in_decode  in  IN_WIDTH x PartialDecodeResult  decoded instruction per lane.
- in_pc  in  IN_WIDTH x 32  PC per lane.
- in_ready  out  1  high when free entries >= IN_WIDTH.
- issue_stall  in  1  backend stall; nothing dequeues this cycle.
- mdu_busy  in  1  MDU occupied; blocks issue of is_mdu instructions.
- out_valid  out  ISSUE_WIDTH  per-slot issue valid; thermometer coded from slot 0.
- out_decode  out  ISSUE_WIDTH x PartialDecodeResult  issued instructions, oldest in slot 0.
- out_pc  out  ISSUE_WIDTH x 32  issued PCs.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset (async assert, sync release):
  - head, tail and count are 0; all entry valid bits are 0.
  - out_valid is 0, occupancy is 0, in_ready is 1.
- Enqueue:
  - Occurs when in_ready and any in_valid bit are high.
  - Enqueued count = popcount(in_valid). Lane i is written to tail+i modulo DEPTH. Tail advances by the enqueued count.
  - Non-packed in_valid is a protocol violation; an assertion fires in simulation.
  - in_ready is computed from the registered count only. Same-cycle dequeue does not free space for that cycle's enqueue.
- Latency: an instruction enqueued at cycle t can be presented at earliest cycle t+1. There is no bypass.
- Issue candidates: slot k presents the entry at head+k when k < count.
- Slot k (k >= 1) is legal only if slot k-1 is legal, and all of the following hold:
  - No RAW against any slot j<k: slot j has reg_write, write_reg_addr != 0, and write_reg_addr equals slot k's rs_addr or rt_addr.
  - No WAW against any slot j<k: both write, same nonzero destination.
  - No WAR against any slot j<k: slot k writes a nonzero register equal to slot j's rs_addr or rt_addr.
  - Neither slot k nor any slot j<k has is_branch or is_mdu; branches and MDU ops issue alone.
  - The memory-access count over slots 0..k is <= MEM_PORTS.
- Slot 0:
  - Legal whenever count >= 1 and issue_stall is low.
  - Exception: an is_mdu instruction at the head is illegal while mdu_busy is high.
- out_valid is combinational from the registered queue state and the current inputs. It is forced to 0 when issue_stall is high.
- Dequeue: head advances by popcount(out_valid) at the clock edge. The issue is accepted unconditionally; there is no output handshake beyond issue_stall.
- Count update: next count = count + enqueued - issued. Head and tail wrap modulo DEPTH.
- Flush:
  - Has priority over enqueue and issue in the same cycle. Both are discarded.
  - Next cycle: count is 0, head equals tail, out_valid is 0.
  - Flush while empty is harmless.
- Reset asserted mid-operation clears the queue immediately; outputs go to their reset values asynchronously.
- Full boundary: when count > DEPTH-IN_WIDTH, in_ready is 0 even if issue is happening that cycle.

Optional Feature:
- Macro: ISSUE_WINDOW_PERF_EN.
- Defined: adds output perf_issue_hist (ISSUE_WIDTH+1 counters, 32 bits each, saturating).
  - Counter n increments in every non-flush cycle with count > 0 in which exactly n instructions issued.
  - Also adds output perf_dep_stall, 32 bits, saturating. It increments when slot 1 has a candidate that is blocked by RAW, WAW or WAR.
  - All counters reset to 0 with reset_n.
- Undefined: neither port exists and no counter logic is synthesised.

Decomposition:
- Shared package MipsDefinitions, extended with:
  - PartialDecodeResult (already present) and ZERO.
  - New constant MAX_ISSUE_WIDTH = 4.
  - New typedef IssueBlockReason enum: NONE, RAW, WAW, WAR, CTRL, MEM, MDU_BUSY. Used by both the checker and the bench.
- Sub-module issue_group_checker: purely combinational.
  - Inputs: ISSUE_WIDTH candidates with valid bits, mdu_busy, issue_stall.
  - Outputs: legal prefix mask and per-slot IssueBlockReason.
  - issue_window holds storage, pointers, flush and perf.

Test Plan:
- Independent ALU pair: addu $1,$2,$3 and addu $4,$5,$6 enqueued at cycle 0 → both valid at cycle 1, occupancy back to 0 at cycle 2.
- RAW: addu $1,$2,$3 then subu $4,$1,$5 → cycle 1 out_valid=01, cycle 2 out_valid=01 with the subu in slot 0.
- Memory and control: lw followed by sw, MEM_PORTS=1 → issued one per cycle. beq followed by addu → beq issues alone.
- MDU: mult at head with mdu_busy=1 for 3 cycles → out_valid=0 for those cycles; mult issues the cycle after mdu_busy drops.
- Full/wrap: DEPTH=8, issue_stall=1, enqueue 2 per cycle → in_ready drops once occupancy=7 or more. Release the stall and run 20 cycles → pointers wrap, all PCs are issued in order.
- Flush: flush asserted with occupancy=5 and a simultaneous enqueue of 2 → occupancy=0 next cycle and no out_valid. With ISSUE_WINDOW_PERF_EN defined, the counters match a reference tally.
